// File: rtl/object_renderer.sv
// Raster pixel walker for the draw sequencer: erases the screen or draws one sprite,
// presenting one VGA pixel per cycle and pulsing a completion flag on the last pixel.
module object_renderer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int PLAYER_W = 8,
  parameter int PLAYER_H = 8,
  parameter int ENEMY_W  = 8,
  parameter int ENEMY_H  = 8,
  parameter int BULLET_W = 1,
  parameter int BULLET_H = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  objectToDraw,
  input  logic        inEraseState,
  input  logic [7:0]  playerX,
  input  logic [6:0]  playerY,
  input  logic [7:0]  bulletX,
  input  logic [6:0]  bulletY,
  input  logic        bulletActive,
  input  logic [31:0] enemyX,
  input  logic [27:0] enemyY,
  input  logic [3:0]  enemyAlive,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        doneDrawing,
  output logic        doneErasing
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, HOLD} state_t;

  // Erase is encoded above the 4-bit sprite codes so it can never alias one.
  localparam logic [4:0] CODE_ERASE = 5'h10;

  state_t      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic        skip_q, skip_d;
  logic [7:0]  bx_q, bx_d, w_q, w_d, cx_q, cx_d;
  logic [6:0]  by_q, by_d, h_q, h_d, cy_q, cy_d;
  logic [2:0]  col_q, col_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d, dd_q, dd_d, de_q, de_d;

  logic [4:0]  req_code;
  logic [7:0]  sel_x, sel_w;
  logic [6:0]  sel_y, sel_h;
  logic [2:0]  sel_col;
  logic        sel_skip;
  logic [1:0]  en_idx;
  logic        last;
  logic        present;
  logic [7:0]  pcx;
  logic [6:0]  pcy;
  logic [8:0]  xs;
  logic [7:0]  ys;
  logic        pix_last;

  logic [7:0]  enemy_x_arr [4];
  logic [6:0]  enemy_y_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_enemy
      assign enemy_x_arr[gi] = enemyX[8*gi +: 8];
      assign enemy_y_arr[gi] = enemyY[7*gi +: 7];
    end
  endgenerate

  assign req_code = inEraseState ? CODE_ERASE : {1'b0, objectToDraw};
  assign en_idx   = objectToDraw[1:0] - 2'd2;
  assign last     = (cx_q == w_q - 8'd1) && (cy_q == h_q - 7'd1);

  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_w    = 8'd1;
    sel_h    = 7'd1;
    sel_col  = 3'b000;
    sel_skip = 1'b1;
    if (inEraseState) begin
      sel_w    = 8'(SCREEN_W);
      sel_h    = 7'(SCREEN_H);
      sel_skip = 1'b0;
    end else begin
      case (objectToDraw)
        4'd1: begin
          sel_x = playerX;  sel_y = playerY;
          sel_w = 8'(PLAYER_W); sel_h = 7'(PLAYER_H);
          sel_col = 3'b010; sel_skip = 1'b0;
        end
        4'd2, 4'd3, 4'd4, 4'd5: begin
          sel_x = enemy_x_arr[en_idx]; sel_y = enemy_y_arr[en_idx];
          sel_w = 8'(ENEMY_W); sel_h = 7'(ENEMY_H);
          sel_col = 3'b100; sel_skip = ~enemyAlive[en_idx];
        end
        4'd6: begin
          sel_x = bulletX;  sel_y = bulletY;
          sel_w = 8'(BULLET_W); sel_h = 7'(BULLET_H);
          sel_col = 3'b110; sel_skip = ~bulletActive;
        end
        default: sel_skip = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      code_q   <= '0;
      skip_q   <= 1'b0;
      bx_q     <= '0;
      by_q     <= '0;
      w_q      <= 8'd1;
      h_q      <= 7'd1;
      col_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      dd_q     <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      skip_q   <= skip_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      dd_q     <= dd_d;
      de_q     <= de_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_code != 5'd0) state_d = LOAD;
      LOAD: state_d = skip_q ? HOLD : DRAW;
      DRAW: if (last) state_d = HOLD;
      HOLD: if (req_code != code_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so each cycle computes the pixel shown in the next one.
  always_comb begin
    code_d   = code_q;
    skip_d   = skip_q;
    bx_d     = bx_q;
    by_d     = by_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x_d      = '0;
    y_d      = '0;
    colour_d = '0;
    plot_d   = 1'b0;
    dd_d     = 1'b0;
    de_d     = 1'b0;
    present  = 1'b0;
    pcx      = '0;
    pcy      = '0;
    case (state_q)
      IDLE: begin
        if (req_code != 5'd0) begin
          code_d = req_code;
          skip_d = sel_skip;
          bx_d   = sel_x;
          by_d   = sel_y;
          w_d    = sel_w;
          h_d    = sel_h;
          col_d  = sel_col;
          dd_d   = sel_skip;
        end
      end
      LOAD: begin
        cx_d = '0;
        cy_d = '0;
        present = ~skip_q;
      end
      DRAW: begin
        if (!last) begin
          if (cx_q == w_q - 8'd1) begin
            cx_d = '0;
            cy_d = cy_q + 7'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
          pcx = cx_d;
          pcy = cy_d;
          present = 1'b1;
        end
      end
      default: ;
    endcase
    xs       = {1'b0, bx_q} + {1'b0, pcx};
    ys       = {1'b0, by_q} + {1'b0, pcy};
    pix_last = (pcx == w_q - 8'd1) && (pcy == h_q - 7'd1);
    if (present) begin
      x_d      = xs[7:0];
      y_d      = ys[6:0];
      colour_d = col_q;
      plot_d   = (xs < 9'(SCREEN_W)) && (ys < 8'(SCREEN_H));
      dd_d     = pix_last && (code_q != CODE_ERASE);
      de_d     = pix_last && (code_q == CODE_ERASE);
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign doneDrawing = dd_q;
  assign doneErasing = de_q;

endmodule

// File: tb/tb_object_renderer.sv
// Scoreboard bench for object_renderer: every plotted pixel and done pulse is
// predicted with its cycle number and matched against the DUT output stream.
module tb_object_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  objectToDraw;
  logic        inEraseState;
  logic [7:0]  playerX, bulletX;
  logic [6:0]  playerY, bulletY;
  logic        bulletActive;
  logic [31:0] enemyX;
  logic [27:0] enemyY;
  logic [3:0]  enemyAlive;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, doneDrawing, doneErasing;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [63:0] exp_q [$];

  object_renderer dut (
    .clk(clk), .reset(reset), .objectToDraw(objectToDraw), .inEraseState(inEraseState),
    .playerX(playerX), .playerY(playerY), .bulletX(bulletX), .bulletY(bulletY),
    .bulletActive(bulletActive), .enemyX(enemyX), .enemyY(enemyY), .enemyAlive(enemyAlive),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .doneDrawing(doneDrawing), .doneErasing(doneErasing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [63:0] ev(input int c, input int xx, input int yy, input int col,
                                     input bit p, input bit dd, input bit de);
    return {11'd0, 32'(c), 8'(xx), 7'(yy), 3'(col), p, dd, de};
  endfunction

  // Predict a raster walk: pixel i appears at c0+2+i; only plotted pixels and the last one are visible.
  task automatic push_sprite(input int c0, input int bx, input int by, input int w, input int h,
                             input int col, input bit erase, input int max_pix);
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        int idx = cy * w + cx;
        int xs = bx + cx;
        int ys = by + cy;
        bit inb = (xs < 160) && (ys < 120);
        bit lst = (idx == w * h - 1);
        if (idx < max_pix && (inb || lst))
          exp_q.push_back(ev(c0 + 2 + idx, xs, ys, col, inb, lst && !erase, lst && erase));
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    objectToDraw = 4'd0;
    inEraseState = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && (plot || doneDrawing || doneErasing)) begin
      logic [63:0] obs;
      obs = {11'd0, 32'(cyc), x, y, colour, plot, doneDrawing, doneErasing};
      if (exp_q.size() == 0) check_eq("extra", obs, 64'd0);
      else check_eq("event", obs, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t;
    reset = 1'b1; objectToDraw = 4'd0; inEraseState = 1'b0;
    playerX = 8'd10; playerY = 7'd20; bulletX = 8'd80; bulletY = 7'd60; bulletActive = 1'b1;
    enemyX = '0; enemyY = '0; enemyAlive = 4'b0000;
    repeat (3) @(posedge clk); #1;
    check_eq("reset_out", 64'({x, y, colour, plot, doneDrawing, doneErasing}), 64'd0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);

    // Full erase, then hand off to the player with no idle gap
    @(posedge clk); #1;
    inEraseState = 1'b1;
    c0 = cyc;
    push_sprite(c0, 0, 0, 160, 120, 0, 1'b1, 1 << 30);
    repeat (19202) @(posedge clk); #1;
    inEraseState = 1'b0;
    objectToDraw = 4'd1;
    push_sprite(cyc + 1, 10, 20, 8, 8, 2, 1'b0, 1 << 30);
    wait_drain(200);

    // Hold with unchanged request, then 0 for one cycle, then bullet
    repeat (100) @(posedge clk); #1;
    objectToDraw = 4'd0;
    @(posedge clk); #1;
    objectToDraw = 4'd6;
    push_sprite(cyc, 80, 60, 1, 4, 6, 1'b0, 1 << 30);
    wait_drain(20);
    go_idle();

    // Enemy 2 clipped at the bottom-right corner
    enemyAlive = 4'b0010;
    enemyX[15:8] = 8'd156;
    enemyY[13:7] = 7'd116;
    @(posedge clk); #1;
    objectToDraw = 4'd3;
    push_sprite(cyc, 156, 116, 8, 8, 4, 1'b0, 1 << 30);
    wait_drain(100);
    go_idle();

    // Skipped requests: dead enemy, then invalid code straight from HOLD, then inactive bullet
    enemyAlive = 4'b1101;
    @(posedge clk); #1;
    objectToDraw = 4'd3;
    exp_q.push_back(ev(cyc + 1, 0, 0, 0, 1'b0, 1'b1, 1'b0));
    repeat (4) @(posedge clk); #1;
    objectToDraw = 4'd7;
    t = cyc;
    exp_q.push_back(ev(t + 2, 0, 0, 0, 1'b0, 1'b1, 1'b0));
    wait_drain(10);
    go_idle();
    bulletActive = 1'b0;
    @(posedge clk); #1;
    objectToDraw = 4'd6;
    exp_q.push_back(ev(cyc + 1, 0, 0, 0, 1'b0, 1'b1, 1'b0));
    wait_drain(10);
    go_idle();

    // Reset at pixel 30 of a player draw, then the draw restarts from scratch
    @(posedge clk); #1;
    objectToDraw = 4'd1;
    c0 = cyc;
    push_sprite(c0, 10, 20, 8, 8, 2, 1'b0, 30);
    repeat (32) @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("reset_mid_out", 64'({x, y, colour, plot, doneDrawing, doneErasing}), 64'd0);
    check_eq("reset_mid_q", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    push_sprite(cyc, 10, 20, 8, 8, 2, 1'b0, 1 << 30);
    wait_drain(100);
    repeat (20) @(posedge clk);
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
